// File: rtl/instr_fetch.sv
// Instruction fetch stage.
// Owns the program counter, reads a combinational ROM and buffers fetched words
// in a two-entry FIFO. Decode receives {instruction, pc} over a valid/ready
// handshake. A redirect from execute loads a new pc and discards everything
// already fetched. Fetching stops once the pc runs past the end of the ROM image.
module instr_fetch #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 20,
  parameter int MEM_DEPTH = 7,
  parameter int RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_read_en,
  output logic              rom_ce,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              fetch_done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [ADDR_W-1:0] MEM_END  = ADDR_W'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(RESET_PC);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;

  // Two-entry FIFO: head points at the oldest entry, count is 0..2.
  logic [DATA_W-1:0] fifo_data [0:1];
  logic [ADDR_W-1:0] fifo_pc   [0:1];
  logic              head;
  logic              tail;
  logic [1:0]        count;

  logic              pop;
  logic              issue;
  logic              flush;

  // Handshake and fetch decisions. A pop frees a slot in the same cycle, so a
  // full FIFO can still accept a new word while decode drains it.
  always_comb begin
    pop     = 1'b0;
    issue   = 1'b0;
    flush   = 1'b0;
    pc_next = pc + ADDR_W'(1);
    tail    = head ^ count[0];
    pop     = (count != 2'd0) && ir_ready;
    flush   = redirect_valid && (state != IDLE);
    issue   = (state == FETCH) && ((count != 2'd2) || pop) && !redirect_valid;
  end

  // Program counter and fetch state machine; a redirect overrides normal fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= START_PC;
    end else begin
      case (state)
        IDLE: begin
          state <= (START_PC < MEM_END) ? FETCH : DONE;
        end
        FETCH, DONE: begin
          if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= (redirect_pc < MEM_END) ? FETCH : DONE;
          end else if (issue) begin
            pc <= pc_next;
            if (pc_next >= MEM_END) begin
              state <= DONE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // FIFO storage and occupancy; a flush empties it and drops any same-cycle pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_pc[0]   <= '0;
      fifo_pc[1]   <= '0;
      head         <= 1'b0;
      count        <= 2'd0;
    end else if (flush) begin
      head  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (issue) begin
        fifo_data[tail] <= rom_data;
        fifo_pc[tail]   <= pc;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({issue, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rom_addr    = pc;
  assign rom_ce      = issue;
  assign rom_read_en = issue;
  assign ir_valid    = (count != 2'd0);
  assign ir_data     = fifo_data[head];
  assign ir_pc       = fifo_pc[head];
  assign fetch_done  = (state == DONE);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with a small combinational ROM model.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic [19:0] rom_addr;
  logic        rom_read_en;
  logic        rom_ce;
  logic [19:0] rom_data;
  logic        redirect_valid;
  logic [19:0] redirect_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic [19:0] ir_data;
  logic [19:0] ir_pc;
  logic        fetch_done;

  int testsRun;
  int testsFailed;

  instr_fetch #(
    .ADDR_W(20), .DATA_W(20), .MEM_DEPTH(7), .RESET_PC(0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_read_en    (rom_read_en),
    .rom_ce         (rom_ce),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .ir_data        (ir_data),
    .ir_pc          (ir_pc),
    .fetch_done     (fetch_done)
  );

  // ROM image: word k holds k+1 for k = 0..6, zero beyond the image.
  assign rom_data = (rom_addr < 20'd7) ? (rom_addr + 20'd1) : 20'd0;

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic rv, input logic [19:0] rpc,
                               input logic rdy);
    rst_n          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    ir_ready       = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;

    // Test 1: reset state, then a straight run through the whole image
    applyStimulus(1'b0, 1'b0, 20'd0, 1'b1);
    tick();
    tick();
    checkOutput("rst_ir_valid", 32'(ir_valid), 32'd0);
    checkOutput("rst_ir_data", 32'(ir_data), 32'd0);
    checkOutput("rst_ir_pc", 32'(ir_pc), 32'd0);
    checkOutput("rst_fetch_done", 32'(fetch_done), 32'd0);
    checkOutput("rst_rom_ce", 32'(rom_ce), 32'd0);
    checkOutput("rst_rom_read_en", 32'(rom_read_en), 32'd0);
    checkOutput("rst_rom_addr", 32'(rom_addr), 32'd0);

    applyStimulus(1'b1, 1'b0, 20'd0, 1'b1);
    tick();
    checkOutput("t1_bubble_valid", 32'(ir_valid), 32'd0);
    checkOutput("t1_first_ce", 32'(rom_ce), 32'd1);
    checkOutput("t1_first_addr", 32'(rom_addr), 32'd0);
    for (int k = 0; k < 7; k++) begin
      tick();
      checkOutput("t1_valid", 32'(ir_valid), 32'd1);
      checkOutput("t1_pc", 32'(ir_pc), 32'(k));
      checkOutput("t1_data", 32'(ir_data), 32'(k + 1));
      checkOutput("t1_done", 32'(fetch_done), (k == 6) ? 32'd1 : 32'd0);
      checkOutput("t1_ce", 32'(rom_ce), (k < 6) ? 32'd1 : 32'd0);
      if (k < 6) checkOutput("t1_addr", 32'(rom_addr), 32'(k + 1));
    end
    tick();
    checkOutput("t1_drained", 32'(ir_valid), 32'd0);
    checkOutput("t1_done_hold", 32'(fetch_done), 32'd1);
    checkOutput("t1_read_en_off", 32'(rom_read_en), 32'd0);

    // Test 2: backpressure fills the FIFO and fetch stops
    applyStimulus(1'b0, 1'b0, 20'd0, 1'b0);
    #1;
    applyStimulus(1'b1, 1'b0, 20'd0, 1'b0);
    tick();
    tick();
    checkOutput("t2_one_entry_ce", 32'(rom_ce), 32'd1);
    checkOutput("t2_one_entry_addr", 32'(rom_addr), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("t2_full_ce", 32'(rom_ce), 32'd0);
      checkOutput("t2_full_addr", 32'(rom_addr), 32'd2);
      checkOutput("t2_hold_data", 32'(ir_data), 32'h00001);
      checkOutput("t2_hold_pc", 32'(ir_pc), 32'd0);
    end

    // Test 6: release backpressure, full FIFO pushes and pops every cycle
    applyStimulus(1'b1, 1'b0, 20'd0, 1'b1);
    for (int k = 1; k < 5; k++) begin
      tick();
      checkOutput("t6_valid", 32'(ir_valid), 32'd1);
      checkOutput("t6_pc", 32'(ir_pc), 32'(k));
      checkOutput("t6_data", 32'(ir_data), 32'(k + 1));
      checkOutput("t6_ce", 32'(rom_ce), 32'd1);
      checkOutput("t6_addr", 32'(rom_addr), 32'(k + 2));
    end

    // Test 5: asynchronous reset mid-stream with a full FIFO
    rst_n = 1'b0;
    #1;
    checkOutput("t5_valid", 32'(ir_valid), 32'd0);
    checkOutput("t5_ce", 32'(rom_ce), 32'd0);
    checkOutput("t5_done", 32'(fetch_done), 32'd0);
    checkOutput("t5_pc", 32'(ir_pc), 32'd0);
    checkOutput("t5_addr", 32'(rom_addr), 32'd0);
    tick();
    // A redirect while still in IDLE must be ignored
    applyStimulus(1'b1, 1'b1, 20'd5, 1'b1);
    tick();
    checkOutput("t5_idle_redirect", 32'(rom_addr), 32'd0);
    applyStimulus(1'b1, 1'b0, 20'd0, 1'b1);
    tick();
    checkOutput("t5_restart_pc", 32'(ir_pc), 32'd0);
    checkOutput("t5_restart_data", 32'(ir_data), 32'h00001);

    // Test 3: redirect flushes buffered pc 1 and 2
    tick();
    checkOutput("t3_head1", 32'(ir_pc), 32'd1);
    ir_ready = 1'b0;
    tick();
    checkOutput("t3_full_ce", 32'(rom_ce), 32'd0);
    applyStimulus(1'b1, 1'b1, 20'd4, 1'b1);
    #1;
    checkOutput("t3_redirect_no_fetch", 32'(rom_ce), 32'd0);
    tick();
    checkOutput("t3_flushed", 32'(ir_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 20'd0, 1'b1);
    #1;
    checkOutput("t3_fetch_ce", 32'(rom_ce), 32'd1);
    checkOutput("t3_fetch_addr", 32'(rom_addr), 32'd4);
    for (int k = 4; k < 7; k++) begin
      tick();
      checkOutput("t3_valid", 32'(ir_valid), 32'd1);
      checkOutput("t3_pc", 32'(ir_pc), 32'(k));
      checkOutput("t3_data", 32'(ir_data), 32'(k + 1));
      checkOutput("t3_done", 32'(fetch_done), (k == 6) ? 32'd1 : 32'd0);
    end
    tick();
    checkOutput("t3_drained", 32'(ir_valid), 32'd0);

    // Test 4: redirect out of DONE back into the image, then past its end
    applyStimulus(1'b1, 1'b1, 20'd2, 1'b1);
    tick();
    checkOutput("t4_done_drop", 32'(fetch_done), 32'd0);
    checkOutput("t4_empty", 32'(ir_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 20'd0, 1'b1);
    #1;
    checkOutput("t4_resume_ce", 32'(rom_ce), 32'd1);
    checkOutput("t4_resume_addr", 32'(rom_addr), 32'd2);
    for (int k = 2; k < 7; k++) begin
      tick();
      checkOutput("t4_pc", 32'(ir_pc), 32'(k));
      checkOutput("t4_done", 32'(fetch_done), (k == 6) ? 32'd1 : 32'd0);
    end
    tick();
    checkOutput("t4_drained", 32'(ir_valid), 32'd0);
    applyStimulus(1'b1, 1'b1, 20'd9, 1'b1);
    #1;
    checkOutput("t4_far_no_ce", 32'(rom_ce), 32'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 20'd0, 1'b1);
    #1;
    checkOutput("t4_far_done", 32'(fetch_done), 32'd1);
    checkOutput("t4_far_ce", 32'(rom_ce), 32'd0);
    checkOutput("t4_far_addr", 32'(rom_addr), 32'd9);
    checkOutput("t4_far_valid", 32'(ir_valid), 32'd0);
    tick();
    checkOutput("t4_far_idle_ce", 32'(rom_ce), 32'd0);
    checkOutput("t4_far_idle_valid", 32'(ir_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
